// File: rtl/osd_seq_pkg.sv
// Shared types and constants for the OSD command sequencer.
package osd_seq_pkg;

   typedef enum logic [1:0] {
      OP_DISABLE     = 2'd0,
      OP_ENABLE      = 2'd1,
      OP_WRITE       = 2'd2,
      OP_ENABLE_INFO = 2'd3
   } osd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FRAME,
      ST_CMD,
      ST_DATA,
      ST_CLOSE
   } osd_state_e;

   localparam logic [15:0] CMD_DISABLE     = 16'h0040;
   localparam logic [15:0] CMD_ENABLE      = 16'h0041;
   localparam logic [15:0] CMD_ENABLE_INFO = 16'h0045;
   localparam logic [15:0] CMD_WRITE       = 16'h0020;

   localparam int INFO_WORDS  = 5;
   localparam int WRITE_WORDS = 256;

   function automatic logic [15:0] cmd_word(input osd_op_e op, input logic [4:0] arg);
      logic [15:0] w;
      case (op)
         OP_DISABLE: w = CMD_DISABLE;
         OP_ENABLE:  w = CMD_ENABLE;
         OP_WRITE:   w = CMD_WRITE | {11'd0, arg};
         default:    w = CMD_ENABLE_INFO;
      endcase
      return w;
   endfunction

   function automatic logic has_data(input osd_op_e op);
      return (op == OP_WRITE) || (op == OP_ENABLE_INFO);
   endfunction

   // Index of the final data word; only meaningful when has_data() is true.
   function automatic logic [7:0] last_index(input osd_op_e op);
      logic [7:0] idx;
      case (op)
         OP_WRITE:       idx = 8'(WRITE_WORDS - 1);
         OP_ENABLE_INFO: idx = 8'(INFO_WORDS - 1);
         default:        idx = 8'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/osd_strobe_pace.sv
// Strobe pacing: one strobe slot every STROBE_GAP+1 cycles once started.
// fire : this edge registers a strobe.
// pre  : this edge registers the fetch for the strobe two edges later, so
//        the one-cycle read latency lands exactly on the strobe edge.
module osd_strobe_pace #(
   parameter int STROBE_GAP = 2
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic start,
   input  logic stop,
   output logic fire,
   output logic pre
);

   localparam logic [3:0] GAP = 4'(STROBE_GAP);

   logic       active;
   logic [3:0] gap_cnt;

   assign fire = active && (gap_cnt == 4'd0);
   // With a single gap cycle the fetch for the next word coincides with the current strobe.
   assign pre  = active && ((STROBE_GAP == 1) ? (gap_cnt == 4'd0) : (gap_cnt == 4'd2));

   // Gap down-counter, reloaded on every strobe.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         active  <= 1'b0;
         gap_cnt <= 4'd0;
      end else if (start) begin
         active  <= 1'b1;
         gap_cnt <= 4'd0;
      end else begin
         if (stop)
            active <= 1'b0;
         if (fire)
            gap_cnt <= GAP;
         else if (gap_cnt != 4'd0)
            gap_cnt <= gap_cnt - 4'd1;
      end
   end

endmodule

// File: rtl/osd_cmd_seq.sv
// OSD command sequencer: arbitrates two requesters and streams a command
// word plus optional buffer words to the osd block.
// Build option: OSD_SEQ_FIXED_PRIO_EN selects fixed priority (requester 1
// always wins) instead of round-robin.
//
// state    | meaning
// IDLE     | waiting for a request; grants and latches it
// FRAME    | one cycle of frame enable before the command
// CMD      | command word strobe
// DATA     | buffer words, fetched two edges ahead of each strobe
// CLOSE    | one frame tail cycle, then two cycles with frame closed
module osd_cmd_seq
   import osd_seq_pkg::*;
#(
   parameter int STROBE_GAP = 2
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   input  logic [1:0][1:0]  req_op,
   input  logic [1:0][4:0]  req_arg,
   output logic [1:0]       req_ready,
   output logic             rd_en,
   output logic             rd_sel,
   output logic [7:0]       rd_addr,
   input  logic [15:0]      rd_data,
   output logic             io_osd,
   output logic             io_strobe,
   output logic [15:0]      io_din,
   output logic             busy
);

   osd_state_e state;
   osd_op_e    op_q;
   logic [4:0] arg_q;
   logic [7:0] fetch_idx;
   logic       fetch_done;
   logic [7:0] send_idx;
   logic [1:0] close_cnt;

   logic       win;
   osd_op_e    win_op;
   logic [7:0] last_idx;
   logic       fetch_go;
   logic       pace_fire;
   logic       pace_pre;
   logic       pace_start;
   logic       pace_stop;

`ifdef OSD_SEQ_FIXED_PRIO_EN
   assign win = req_valid[1];
`else
   logic last_grant;

   assign win = (&req_valid) ? ~last_grant : req_valid[1];

   // Round-robin history: the last granted requester loses the next tie.
   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         last_grant <= 1'b1;
      else if ((state == ST_IDLE) && (|req_valid))
         last_grant <= win;
   end
`endif

   assign win_op     = osd_op_e'(req_op[win]);
   assign last_idx   = last_index(op_q);
   assign fetch_go   = pace_pre && !fetch_done && ((state == ST_CMD) || (state == ST_DATA));
   assign pace_start = (state == ST_FRAME);
   assign pace_stop  = pace_fire &&
                       (((state == ST_CMD) && !has_data(op_q)) ||
                        ((state == ST_DATA) && (send_idx == last_idx)));

   osd_strobe_pace #(.STROBE_GAP(STROBE_GAP)) u_pace (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .start   (pace_start),
      .stop    (pace_stop),
      .fire    (pace_fire),
      .pre     (pace_pre)
   );

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         op_q       <= OP_DISABLE;
         arg_q      <= 5'd0;
         fetch_idx  <= 8'd0;
         fetch_done <= 1'b1;
         send_idx   <= 8'd0;
         close_cnt  <= 2'd0;
         req_ready  <= 2'b00;
         rd_en      <= 1'b0;
         rd_sel     <= 1'b0;
         rd_addr    <= 8'd0;
         io_osd     <= 1'b0;
         io_strobe  <= 1'b0;
         io_din     <= 16'd0;
         busy       <= 1'b0;
      end else begin
         req_ready <= 2'b00;
         io_strobe <= 1'b0;
         rd_en     <= 1'b0;

         // The fetch index wraps after word 255; fetch_done stops any further fetch.
         if (fetch_go) begin
            rd_en     <= 1'b1;
            rd_addr   <= fetch_idx;
            fetch_idx <= fetch_idx + 8'd1;
            if (fetch_idx == last_idx)
               fetch_done <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (|req_valid) begin
                  req_ready  <= win ? 2'b10 : 2'b01;
                  op_q       <= win_op;
                  arg_q      <= req_arg[win];
                  rd_sel     <= win;
                  rd_addr    <= 8'd0;
                  fetch_idx  <= 8'd0;
                  fetch_done <= !has_data(win_op);
                  send_idx   <= 8'd0;
                  busy       <= 1'b1;
                  state      <= ST_FRAME;
               end
            end
            ST_FRAME: begin
               io_osd <= 1'b1;
               state  <= ST_CMD;
            end
            ST_CMD: begin
               if (pace_fire) begin
                  io_strobe <= 1'b1;
                  io_din    <= cmd_word(op_q, arg_q);
                  close_cnt <= 2'd3;
                  state     <= has_data(op_q) ? ST_DATA : ST_CLOSE;
               end
            end
            ST_DATA: begin
               if (pace_fire) begin
                  io_strobe <= 1'b1;
                  io_din    <= (op_q == OP_WRITE) ? {8'h00, rd_data[7:0]} : rd_data;
                  send_idx  <= send_idx + 8'd1;
                  if (send_idx == last_idx) begin
                     close_cnt <= 2'd3;
                     state     <= ST_CLOSE;
                  end
               end
            end
            ST_CLOSE: begin
               if (close_cnt == 2'd0) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  close_cnt <= close_cnt - 2'd1;
                  if (close_cnt != 2'd3)
                     io_osd <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_osd_cmd_seq.sv
// Testbench for osd_cmd_seq: randomized requests, reference model of the
// expected word stream and fetch sequence, scoreboard monitor.
module tb_osd_cmd_seq;

   localparam int GAP = 2;

   logic             clk_sys = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       req_valid = 2'b00;
   logic [1:0][1:0]  req_op = '0;
   logic [1:0][4:0]  req_arg = '0;
   logic [1:0]       req_ready;
   logic             rd_en;
   logic             rd_sel;
   logic [7:0]       rd_addr;
   logic [15:0]      rd_data = 16'd0;
   logic             io_osd;
   logic             io_strobe;
   logic [15:0]      io_din;
   logic             busy;

   osd_cmd_seq #(.STROBE_GAP(GAP)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_arg   (req_arg),
      .req_ready (req_ready),
      .rd_en     (rd_en),
      .rd_sel    (rd_sel),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .io_osd    (io_osd),
      .io_strobe (io_strobe),
      .io_din    (io_din),
      .busy      (busy)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] mem [2][256];
   logic [15:0] exp_din [$];
   logic [8:0]  exp_fetch [$];

   bit [1:0]    pending = 2'b00;
   logic [1:0]  p_op [2];
   logic [4:0]  p_arg [2];
   int          last_w = 1;
   int          strobe_seen = 0;

   // Buffer memory: data valid exactly one cycle after rd_en, junk otherwise.
   always @(posedge clk_sys)
      rd_data <= rd_en ? mem[rd_sel][rd_addr] : 16'($urandom);

   function automatic void check_eq(string name, longint act, longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int model_win(bit [1:0] p, int last);
`ifdef OSD_SEQ_FIXED_PRIO_EN
      return p[1] ? 1 : 0;
`else
      if (p == 2'b11) return 1 - last;
      return p[1] ? 1 : 0;
`endif
   endfunction

   // Expected response of a granted request, from the command table.
   function automatic void push_expected(int w);
      logic [15:0] cmd;
      logic [15:0] d;
      int n;
      case (p_op[w])
         2'd0: begin cmd = 16'h0040; n = 0; end
         2'd1: begin cmd = 16'h0041; n = 0; end
         2'd2: begin cmd = 16'h0020 + 16'(p_arg[w]); n = 256; end
         default: begin cmd = 16'h0045; n = 5; end
      endcase
      exp_din.push_back(cmd);
      for (int k = 0; k < n; k++) begin
         d = mem[w][k];
         exp_din.push_back((p_op[w] == 2'd2) ? {8'h00, d[7:0]} : d);
         exp_fetch.push_back({w[0], 8'(k)});
      end
   endfunction

   task automatic drive();
      req_valid  = pending;
      req_op[0]  = p_op[0];
      req_op[1]  = p_op[1];
      req_arg[0] = p_arg[0];
      req_arg[1] = p_arg[1];
   endtask

   task automatic new_req(int i);
      pending[i] = 1'b1;
      p_op[i]    = 2'($urandom_range(0, 3));
      p_arg[i]   = 5'($urandom_range(0, 31));
   endtask

   task automatic wait_grant(output int w);
      w = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_sys);
         if (req_ready != 2'b00) begin
            check_eq("req_ready_onehot", $countones(req_ready), 1);
            w = req_ready[1] ? 1 : 0;
            break;
         end
      end
   endtask

   task automatic run_grant(input bit hold, output int w);
      int e;
      e = model_win(pending, last_w);
      drive();
      wait_grant(w);
      check_eq("grant_winner", w, e);
      if (w >= 0) begin
         push_expected(w);
         last_w = w;
         if (!hold) pending[w] = 1'b0;
         drive();
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_sys);
         if (!busy) break;
      end
      check_eq("idle_reached_busy", busy, 0);
   endtask

   task automatic check_reset_outputs(string tag);
      check_eq({tag, "_io_osd"},    io_osd, 0);
      check_eq({tag, "_io_strobe"}, io_strobe, 0);
      check_eq({tag, "_io_din"},    io_din, 0);
      check_eq({tag, "_rd_en"},     rd_en, 0);
      check_eq({tag, "_rd_addr"},   rd_addr, 0);
      check_eq({tag, "_rd_sel"},    rd_sel, 0);
      check_eq({tag, "_req_ready"}, req_ready, 0);
      check_eq({tag, "_busy"},      busy, 0);
   endtask

   // Monitor: scoreboard for strobes and fetches, plus timing rules.
   initial begin : monitor
      int cyc = 0;
      int prev_cyc = 0;
      bit have_prev = 0;
      bit prev_busy = 0;
      logic [15:0] last_din = 16'd0;
      logic [15:0] e;
      logic [8:0]  f;
      forever begin
         @(posedge clk_sys);
         #1;
         cyc++;
         if (!reset_n) begin
            have_prev = 0;
            prev_busy = 0;
            last_din  = 16'd0;
            continue;
         end
         if (req_ready != 2'b00)
            check_eq("grant_while_busy", prev_busy, 0);
         if (rd_en) begin
            if (exp_fetch.size() == 0) begin
               check_eq("extra_fetch", exp_fetch.size(), 1);
            end else begin
               f = exp_fetch.pop_front();
               check_eq("rd_addr", rd_addr, f[7:0]);
               check_eq("rd_sel", rd_sel, f[8]);
            end
         end
         if (!io_osd) have_prev = 0;
         if (io_strobe) begin
            strobe_seen++;
            check_eq("osd_during_strobe", io_osd, 1);
            if (have_prev) check_eq("strobe_spacing", cyc - prev_cyc, GAP + 1);
            prev_cyc  = cyc;
            have_prev = 1;
            if (exp_din.size() == 0) begin
               check_eq("unexpected_strobe", exp_din.size(), 1);
            end else begin
               e = exp_din.pop_front();
               check_eq("io_din", io_din, e);
            end
         end else begin
            check_eq("io_din_stable", io_din, last_din);
         end
         last_din  = io_din;
         prev_busy = busy;
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int w;
      int base;
      int grants [4];
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < 256; k++)
            mem[b][k] = 16'($urandom);
      p_op[0] = 2'd0; p_op[1] = 2'd0;
      p_arg[0] = 5'd0; p_arg[1] = 5'd0;

      repeat (4) @(negedge clk_sys);
      check_reset_outputs("in_reset");
      reset_n = 1'b1;
      @(negedge clk_sys);
      check_reset_outputs("after_reset");

      // DISABLE from requester 0: exact frame timing.
      pending = 2'b01; p_op[0] = 2'd0; p_arg[0] = 5'($urandom_range(0, 31));
      run_grant(0, w);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk_sys);
         check_eq($sformatf("disable_c%0d_osd", c), io_osd, (c >= 1 && c <= 3) ? 1 : 0);
         check_eq($sformatf("disable_c%0d_strobe", c), io_strobe, (c == 2) ? 1 : 0);
         check_eq($sformatf("disable_c%0d_busy", c), busy, (c <= 5) ? 1 : 0);
         if (c == 2) check_eq("disable_cmd", io_din, 16'h0040);
      end
      wait_idle();

      // ENABLE_INFO with a known buffer.
      mem[0][0] = 16'h0010; mem[0][1] = 16'h0020; mem[0][2] = 16'h0008;
      mem[0][3] = 16'h0004; mem[0][4] = 16'h0001;
      pending = 2'b01; p_op[0] = 2'd3; p_arg[0] = 5'($urandom_range(0, 31));
      run_grant(0, w);
      wait_idle();
      check_eq("info_words_left", exp_din.size(), 0);

      // WRITE arg 0x0B from requester 1.
      pending = 2'b10; p_op[1] = 2'd2; p_arg[1] = 5'h0B;
      run_grant(0, w);
      wait_idle();
      check_eq("write_words_left", exp_din.size(), 0);
      check_eq("write_fetches_left", exp_fetch.size(), 0);

      // Both requesters held valid with WRITE.
      pending = 2'b11; p_op[0] = 2'd2; p_op[1] = 2'd2;
      p_arg[0] = 5'($urandom_range(0, 31)); p_arg[1] = 5'($urandom_range(0, 31));
      for (int g = 0; g < 4; g++) begin
         run_grant(1, w);
         grants[g] = w;
      end
      pending = 2'b00;
      drive();
      for (int g = 0; g < 4; g++) begin
`ifdef OSD_SEQ_FIXED_PRIO_EN
         check_eq($sformatf("fixed_prio_g%0d", g), grants[g], 1);
`else
         check_eq($sformatf("round_robin_g%0d", g), grants[g], g % 2);
`endif
      end
      wait_idle();

      // Random traffic, requests changing while the sequencer is busy.
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 2; i++)
            if (!pending[i] && ($urandom_range(0, 1) == 1)) new_req(i);
         if (pending == 2'b00) new_req($urandom_range(0, 1));
         run_grant(0, w);
      end
      pending = 2'b00;
      drive();
      wait_idle();
      check_eq("random_words_left", exp_din.size(), 0);
      check_eq("random_fetches_left", exp_fetch.size(), 0);

      // Reset pulse during WRITE word 100.
      pending = 2'b10; p_op[1] = 2'd2; p_arg[1] = 5'($urandom_range(0, 31));
      run_grant(0, w);
      base = strobe_seen;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_sys);
         if (strobe_seen - base >= 102) break;
      end
      check_eq("word100_reached", (strobe_seen - base >= 102) ? 1 : 0, 1);
      reset_n = 1'b0;
      @(negedge clk_sys);
      check_reset_outputs("mid_reset");
      reset_n = 1'b1;
      exp_din.delete();
      exp_fetch.delete();
      last_w = 1;

      // Tie straight after reset, then the frame restarts cleanly.
      pending = 2'b11;
      p_op[0] = 2'd3; p_arg[0] = 5'($urandom_range(0, 31));
      p_op[1] = 2'd1; p_arg[1] = 5'($urandom_range(0, 31));
      run_grant(0, w);
`ifndef OSD_SEQ_FIXED_PRIO_EN
      check_eq("tie_after_reset", w, 0);
`endif
      pending = 2'b00;
      drive();
      @(negedge clk_sys);
      check_eq("restart_frame_osd", io_osd, 1);
      check_eq("restart_frame_strobe", io_strobe, 0);
      wait_idle();
      check_eq("final_words_left", exp_din.size(), 0);
      check_eq("final_fetches_left", exp_fetch.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
